// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// Build option: RF_BYPASS_EN enables write-to-read forwarding.
package rf_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry writing zero after reset or on request.
// Build option: RF_BYPASS_EN (not used here).
module rf_clear_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clearReq_i,
  output logic              ready_o,
  output logic              clearing_o,
  output logic              clrWe_o,
  output logic [ADDR_W-1:0] clrAddr_o
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clrCnt_q, clrCnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RF_CLEAR;
      clrCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      clrCnt_q <= clrCnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    clrCnt_d = clrCnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        // stop on the last entry so the counter never wraps
        if (clrCnt_q == LAST) begin
          state_d  = RF_RUN;
          clrCnt_d = '0;
        end else begin
          clrCnt_d = clrCnt_q + 1'b1;
        end
      end
      RF_RUN: begin
        if (clearReq_i) begin
          state_d  = RF_CLEAR;
          clrCnt_d = '0;
        end
      end
      default: state_d = RF_CLEAR;
    endcase
  end

  assign ready_o    = (state_q == RF_RUN);
  assign clearing_o = (state_q == RF_CLEAR);
  assign clrWe_o    = (state_q == RF_CLEAR);
  assign clrAddr_o  = clrCnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with clear sequencer and drop reporting.
// Build option: RF_BYPASS_EN forwards the same-cycle write to matching reads.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     clearReq,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic                     ready,
  output logic                     wrDropped,
  output logic                     clearing
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clrWe;
  logic [ADDR_W-1:0] clrAddr;
  logic              wrZero;
  logic              userWe;
  logic              wrDropped_q, wrDropped_d;

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .reset     (reset),
    .clearReq_i(clearReq),
    .ready_o   (ready),
    .clearing_o(clearing),
    .clrWe_o   (clrWe),
    .clrAddr_o (clrAddr)
  );

  assign wrZero = (ZERO_REG != 0) && (writeReg == '0);
  assign userWe = ready && regWrite && !clearReq
                  && !reset && !wrZero;
  assign wrDropped_d = regWrite && (clearing || clearReq);

  always_ff @(posedge clk) begin
    if (reset) wrDropped_q <= 1'b0;
    else       wrDropped_q <= wrDropped_d;
  end

  assign wrDropped = wrDropped_q;

  always_ff @(posedge clk) begin
    if (clrWe)       mem_q[clrAddr]  <= '0;
    else if (userWe) mem_q[writeReg] <= writeData;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic              byp;

    assign ra = readReg[slice_lo(i, ADDR_W) +: ADDR_W];
`ifdef RF_BYPASS_EN
    assign byp = userWe && (writeReg == ra);
`else
    assign byp = 1'b0;
`endif

    always_comb begin
      rd = mem_q[ra];
      if (byp) rd = writeData;
      if (clearing || (ZERO_REG != 0 && ra == '0)) rd = '0;
    end

    assign readData[slice_lo(i, DATA_W) +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomised and directed bench for reg_file_mp against a behavioural model.
// Build option: RF_BYPASS_EN changes the same-cycle read expectation.
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, regWrite, clearReq;
  logic [4:0]  writeReg;
  logic [31:0] writeData;
  logic [9:0]  readReg;
  logic [63:0] readData;
  logic        ready, wrDropped, clearing;

  logic [15:0] wd16;
  logic [19:0] readReg4;
  logic [63:0] readData4;
  logic        ready4, wrDropped4, clearing4;

  assign wd16 = writeData[15:0];

  reg_file_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)
  ) u_dut (
    .clk(clk), .reset(reset), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(writeData),
    .clearReq(clearReq), .readReg(readReg),
    .readData(readData), .ready(ready),
    .wrDropped(wrDropped), .clearing(clearing)
  );

  reg_file_mp #(
    .DATA_W(16), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1)
  ) u_dut4 (
    .clk(clk), .reset(reset), .regWrite(regWrite),
    .writeReg(writeReg), .writeData(wd16),
    .clearReq(clearReq), .readReg(readReg4),
    .readData(readData4), .ready(ready4),
    .wrDropped(wrDropped4), .clearing(clearing4)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mdl_mem [32];
  int          clr_left = 0;
  logic        mdl_drop = 1'b0;
  logic        mdl_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    if (clr_left > 0 || a == 5'd0) return 32'h0;
    v = mdl_mem[a];
`ifdef RF_BYPASS_EN
    if (!reset && regWrite && !clearReq && writeReg == a) v = writeData;
`endif
    return v;
  endfunction

  task automatic check_outputs();
    chk("ready", ready, clr_left == 0);
    chk("clearing", clearing, clr_left > 0);
    chk("wrDropped", wrDropped, mdl_drop);
    chk("ready4", ready4, clr_left == 0);
    chk("wrDropped4", wrDropped4, mdl_drop);
    for (int i = 0; i < 2; i++)
      chk($sformatf("rd%0d", i), readData[i*32 +: 32],
          exp_rd(readReg[i*5 +: 5]));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rd4_%0d", i), readData4[i*16 +: 16],
          exp_rd(readReg4[i*5 +: 5]) & 32'h0000_FFFF);
  endtask

  // Whole array zeroed at once; reads are masked until the clear finishes.
  task automatic start_clear();
    for (int k = 0; k < 32; k++) mdl_mem[k] = 32'h0;
    clr_left = 32;
  endtask

  task automatic model_update();
    if (reset) begin
      mdl_valid = 1'b1;
      mdl_drop  = 1'b0;
      start_clear();
    end else begin
      mdl_drop = regWrite && (clr_left > 0 || clearReq);
      if (clr_left > 0) clr_left--;
      else if (clearReq) start_clear();
      else if (regWrite && writeReg != 5'd0) mdl_mem[writeReg] = writeData;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (mdl_valid) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  initial begin
    int n;
    reset = 1'b1; regWrite = 1'b0; clearReq = 1'b0;
    writeReg = '0; writeData = '0; readReg = '0; readReg4 = '0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_clearing", clearing, 1);
    chk("rst_ready", ready, 0);
    wait_ready("clr_len", 32);
    readReg = {5'd2, 5'd1};
    #1;
    chk("rd_init", readData, 64'h0);

    regWrite = 1'b1; writeReg = 5'd1; writeData = 32'h12345678;
    tick();
    writeReg = 5'd2; writeData = 32'h87654321;
    tick();
    regWrite = 1'b0;
    #1;
    chk("rd_pair", readData, {32'h87654321, 32'h12345678});

    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFFFFFF;
    readReg = {5'd0, 5'd0};
    tick();
    regWrite = 1'b0;
    #1;
    chk("zero_reg", readData, 64'h0);
    chk("zero_nodrop", wrDropped, 0);

    regWrite = 1'b1; writeReg = 5'd3; writeData = 32'hAABBCCDD;
    readReg = {5'd1, 5'd3};
    #1;
`ifdef RF_BYPASS_EN
    chk("same_cyc", readData[31:0], 32'hAABBCCDD);
`else
    chk("same_cyc", readData[31:0], 32'h0);
`endif
    tick();
    regWrite = 1'b0;
    #1;
    chk("after_wr", readData[31:0], 32'hAABBCCDD);

    for (int k = 0; k < 4; k++) begin
      regWrite = 1'b1;
      writeReg = 5'(10 + k);
      writeData = 32'h1000 + 32'(k) * 32'h1111;
      tick();
    end
    regWrite = 1'b0;
    readReg4 = {5'd13, 5'd12, 5'd11, 5'd10};
    #1;
    chk("rd4_quad", readData4, {16'h4333, 16'h3222, 16'h2111, 16'h1000});

    regWrite = 1'b1; writeReg = 5'd5; writeData = 32'h55; clearReq = 1'b1;
    tick();
    regWrite = 1'b0; clearReq = 1'b0;
    #1;
    chk("drop_clr", wrDropped, 1);
    chk("ready_fall", ready, 0);
    wait_ready("clr_len2", 32);
    readReg = {5'd1, 5'd5};
    #1;
    chk("cleared", readData, 64'h0);

    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    n = 0;
    while (!ready && n < 40) begin
      regWrite = (n == 3);
      writeReg = 5'd7; writeData = 32'h77;
      clearReq = (n == 5);
      tick();
      if (n == 3) chk("drop_in_clr", wrDropped, 1);
      n++;
    end
    regWrite = 1'b0; clearReq = 1'b0;
    chk("clr_len3", n, 32);
    readReg = {5'd7, 5'd7};
    #1;
    chk("r7_zero", readData, 64'h0);

    clearReq = 1'b1;
    tick();
    clearReq = 1'b0;
    repeat (10) tick();
    reset = 1'b1; regWrite = 1'b1; writeReg = 5'd9; clearReq = 1'b1;
    tick();
    reset = 1'b0; regWrite = 1'b0; clearReq = 1'b0;
    #1;
    chk("rst_nodrop", wrDropped, 0);
    wait_ready("clr_len4", 32);

    repeat (600) begin
      regWrite  = 1'($urandom_range(0, 1));
      writeReg  = 5'($urandom);
      writeData = $urandom;
      clearReq  = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 299) == 0);
      readReg   = 10'($urandom);
      readReg4  = 20'($urandom);
      if ($urandom_range(0, 2) == 0) readReg[4:0] = writeReg;
      if ($urandom_range(0, 2) == 0) readReg4[19:15] = writeReg;
      tick();
    end
    reset = 1'b0; regWrite = 1'b0; clearReq = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
